pll_reset_sequencer: RTL and testbench
======================================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter LOCK_CYCLES, default 1000: consecutive synced-locked refclk cycles required before reset release begins.
REQ-002 SHALL have parameter STAGE_GAP, default 16: refclk cycles between successive stage releases.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 500000: refclk cycles spent in WAIT_LOCK before the PLL is re-reset.
REQ-004 SHALL have parameter PLL_RST_CYCLES, default 50: width of the pll_rst pulse in refclk cycles.
REQ-005 SHALL have port refclk, input, 1 bit: the single clock (50 MHz board reference, free-running independent of PLL).
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port locked, input, 1 bit: PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port pll_rst, output, 1 bit: reset drive to the PLL rst input.
REQ-009 SHALL have port sync_locked, output, 1 bit: locked after a 2-flop synchronizer.
REQ-010 SHALL have port rst_stage, output, 4 bits: active-high stage resets; bit 0 released first, bit 3 last.
REQ-011 SHALL have port ready, output, 1 bit: high only in RUN.
REQ-012 SHALL have port retries, output, 8 bits: count of timeout-triggered PLL re-resets.

Function
REQ-013 SHALL synchronize locked through exactly two refclk flops; sync_locked follows locked with a 2-cycle latency.
REQ-014 SHALL implement states PLLRST, WAIT_LOCK, STABLE, RELEASE, RUN, with one 20-bit cycle counter cleared on every state change; all parameters SHALL be at most 2^20-1 and at least 1.
REQ-015 PLLRST: pll_rst=1, rst_stage=4'b1111; after PLL_RST_CYCLES cycles SHALL go to WAIT_LOCK.
REQ-016 WAIT_LOCK: pll_rst=0, rst_stage=4'b1111; sync_locked=1 SHALL go to STABLE; otherwise, when the counter reaches TIMEOUT_CYCLES-1, SHALL go to PLLRST and increment retries.
REQ-017 STABLE: sync_locked=0 in any cycle SHALL return to WAIT_LOCK, restarting qualification; after LOCK_CYCLES consecutive cycles with sync_locked=1 SHALL go to RELEASE.
REQ-018 RELEASE: rst_stage[0] SHALL fall on the first RELEASE cycle, exactly LOCK_CYCLES+1 cycles after sync_locked rises.
REQ-019 RELEASE: rst_stage[k] SHALL fall exactly STAGE_GAP cycles after rst_stage[k-1], for k=1..3.
REQ-020 RELEASE: SHALL enter RUN on the cycle rst_stage[3] falls; ready SHALL rise in that same cycle.
REQ-021 RUN: outputs SHALL hold rst_stage=4'b0000 and ready=1 while sync_locked=1.
REQ-022 Loss of lock (sync_locked=0) in RELEASE or RUN SHALL move to WAIT_LOCK; on the next refclk edge, rst_stage SHALL be 4'b1111, ready SHALL be 0 and pll_rst SHALL stay 0.
REQ-023 Loss of lock SHALL NOT increment retries.
REQ-024 retries SHALL saturate at 255.
REQ-025 All outputs SHALL be registered; no output SHALL glitch combinationally.
REQ-026 A lock rise in the same cycle the WAIT_LOCK timeout expires SHALL be ignored; timeout SHALL take priority, giving PLLRST.

Reset
REQ-027 rst=1 SHALL asynchronously force: state PLLRST, counter 0, synchronizer flops 0, pll_rst=1, rst_stage=4'b1111, ready=0, sync_locked=0, retries=0.
REQ-028 On rst deassertion, PLLRST SHALL run a full PLL_RST_CYCLES from count 0.
REQ-029 rst asserted mid-RELEASE or mid-RUN SHALL immediately re-assert all rst_stage bits and pll_rst.

Verification (LOCK_CYCLES=8, STAGE_GAP=4, TIMEOUT_CYCLES=32, PLL_RST_CYCLES=3)
REQ-030 Scenario: rst released, locked rises at cycle 10 -> pll_rst low after 3 cycles; sync_locked high 2 cycles after locked; rst_stage[0..3] fall at 9, 13, 17 and 21 cycles after sync_locked rises; ready=1 with rst_stage[3] fall.
REQ-031 Scenario: locked held 0 -> pll_rst pulses 3 cycles wide every 35 cycles; retries counts 1, 2, 3, ...; driven for 300 pulses, retries stays at 255.
REQ-032 Scenario: in STABLE at count 5, locked drops for 3 cycles then returns -> release occurs LOCK_CYCLES+1 cycles after the new sync_locked rise.
REQ-033 Scenario: in RUN, locked falls -> rst_stage=4'b1111 and ready=0 within 3 cycles of the locked fall; retries unchanged.
REQ-034 Scenario: rst pulsed between the rst_stage[1] and rst_stage[2] releases -> outputs return to reset values asynchronously, and the full sequence replays.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: pulses the PLL reset, qualifies lock, then releases
// four downstream reset stages in order, one every STAGE_GAP cycles.
// Ports:
//   refclk      - free-running board reference clock
//   rst         - asynchronous active-high reset
//   locked      - PLL lock, asynchronous to refclk
//   pll_rst     - reset drive to the PLL
//   sync_locked - locked after a 2-flop synchronizer
//   rst_stage   - active-high stage resets, bit 0 released first
//   ready       - high only once all stages are released
//   retries     - saturating count of timeout-triggered PLL re-resets
module pll_reset_sequencer #(
  parameter int unsigned LOCK_CYCLES    = 1000,
  parameter int unsigned STAGE_GAP      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned PLL_RST_CYCLES = 50
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sync_locked,
  output logic [3:0] rst_stage,
  output logic       ready,
  output logic [7:0] retries
);

  localparam int unsigned CNT_W = 20;
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_PLLRST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             meta_q;
  logic             sync_q;
  logic             pll_rst_q;
  logic [3:0]       stage_q;
  logic             ready_q;
  logic [7:0]       retries_q;

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= locked;
      sync_q <= meta_q;
    end
  end

  // Sequencer FSM; the counter restarts from 0 on every state change and
  // on every stage release inside RELEASE.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      stage_q   <= 4'b1111;
      ready_q   <= 1'b0;
      retries_q <= 8'd0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        ST_PLLRST: begin
          if (cnt_q == PLLRST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end
        end
        ST_WAIT_LOCK: begin
          // Timeout wins over a lock seen in the same cycle.
          if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= ST_PLLRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retries_q != 8'hFF) begin
              retries_q <= retries_q + 8'd1;
            end
          end else if (sync_q) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
          end
        end
        ST_STABLE: begin
          if (!sync_q) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
          end else if (cnt_q == LOCK_LAST) begin
            state_q <= ST_RELEASE;
            cnt_q   <= '0;
            stage_q <= 4'b1110;
          end
        end
        ST_RELEASE: begin
          if (!sync_q) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            stage_q <= 4'b1111;
          end else if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            stage_q <= {stage_q[2:0], 1'b0};
            // Last stage releasing: ready rises together with it.
            if (stage_q == 4'b1000) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          cnt_q <= cnt_q;
          if (!sync_q) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            stage_q <= 4'b1111;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_PLLRST;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          stage_q   <= 4'b1111;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sync_locked = sync_q;
  assign rst_stage   = stage_q;
  assign ready       = ready_q;
  assign retries     = retries_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario tasks plus randomized lock traffic,
// checked against a timestamp-based reference model of the sequencer.
// Ports: none (drives refclk, rst, locked into pll_reset_sequencer).
module tb_pll_reset_sequencer;

  localparam int L = 8;
  localparam int G = 4;
  localparam int T = 32;
  localparam int P = 3;

  logic       refclk = 1'b0;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic       sync_locked;
  logic [3:0] rst_stage;
  logic       ready;
  logic [7:0] retries;

  pll_reset_sequencer #(
    .LOCK_CYCLES   (L),
    .STAGE_GAP     (G),
    .TIMEOUT_CYCLES(T),
    .PLL_RST_CYCLES(P)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .locked     (locked),
    .pll_rst    (pll_rst),
    .sync_locked(sync_locked),
    .rst_stage  (rst_stage),
    .ready      (ready),
    .retries    (retries)
  );

  always #5 refclk = ~refclk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: edge counter plus timestamps of the PLL pulse end,
  // the start of the current lock wait and the edge where lock was accepted.
  int          cyc       = 0;
  int          pll_until = 0;
  int          w_start   = 0;
  int          r_edge    = -1;
  bit          in_pll    = 1'b1;
  bit          s1        = 1'b0;
  bit          s2        = 1'b0;
  int          m_retries = 0;
  logic [14:0] exp_vec;
  logic [14:0] dut_vec;

  assign dut_vec = {pll_rst, sync_locked, rst_stage, ready, retries};

  function automatic logic [14:0] model_out();
    logic [3:0] st;
    logic       rdy;
    int         e;
    st  = 4'hF;
    rdy = 1'b0;
    if (r_edge >= 0) begin
      e = cyc - r_edge;
      for (int k = 0; k < 4; k++) st[k] = (e < L + k * G);
      rdy = (e >= L + 3 * G);
    end
    return {in_pll, s2, st, rdy, 8'(m_retries)};
  endfunction

  always @(posedge refclk or posedge rst) begin
    if (rst) begin
      in_pll    = 1'b1;
      pll_until = cyc + P;
      r_edge    = -1;
      s1        = 1'b0;
      s2        = 1'b0;
      m_retries = 0;
    end else begin : step
      bit seen;
      cyc  = cyc + 1;
      seen = s2;
      s2   = s1;
      s1   = locked;
      if (in_pll) begin
        if (cyc >= pll_until) begin
          in_pll  = 1'b0;
          w_start = cyc;
        end
      end else if (r_edge < 0) begin
        if (cyc == w_start + T) begin
          in_pll    = 1'b1;
          pll_until = cyc + P;
          if (m_retries < 255) m_retries = m_retries + 1;
        end else if (seen) begin
          r_edge = cyc;
        end
      end else if (!seen) begin
        r_edge  = -1;
        w_start = cyc;
      end
    end
    exp_vec = model_out();
  end

  task automatic do_reset(input logic lk);
    @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    rst    = 1'b0;
    locked = lk;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    locked = 1'b0;
    repeat (3) @(negedge refclk);
    n_checks++;
    if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst got %b want 1", pll_rst);
    else n_pass++;
    n_checks++;
    if (rst_stage !== 4'hF) $display("FAIL reset_stage got %b want 1111", rst_stage);
    else n_pass++;
    n_checks++;
    if (ready !== 1'b0) $display("FAIL reset_ready got %b want 0", ready);
    else n_pass++;
    n_checks++;
    if (sync_locked !== 1'b0) $display("FAIL reset_sync got %b want 0", sync_locked);
    else n_pass++;
    n_checks++;
    if (retries !== 8'd0) $display("FAIL reset_retries got %0d want 0", retries);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_lock_sequence();
    int t_pll, t_sync, t_rdy;
    int t_s[4];
    t_pll = -1; t_sync = -1; t_rdy = -1;
    for (int k = 0; k < 4; k++) t_s[k] = -1;
    do_reset(1'b0);
    for (int n = 1; n <= 60; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_lockseq cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
      if (t_pll < 0 && !pll_rst) t_pll = n;
      if (t_sync < 0 && sync_locked) t_sync = n;
      for (int k = 0; k < 4; k++) if (t_s[k] < 0 && !rst_stage[k]) t_s[k] = n;
      if (t_rdy < 0 && ready) t_rdy = n;
      if (n == 10) locked = 1'b1;
    end
    n_checks++;
    if (t_pll !== 3) $display("FAIL lockseq_pll_fall got %0d want 3", t_pll);
    else n_pass++;
    n_checks++;
    if (t_sync - 10 !== 2) $display("FAIL lockseq_sync_latency got %0d want 2", t_sync - 10);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (t_s[k] - t_sync !== L + 1 + k * G)
        $display("FAIL lockseq_stage%0d got %0d want %0d", k, t_s[k] - t_sync, L + 1 + k * G);
      else n_pass++;
    end
    n_checks++;
    if (t_rdy !== t_s[3] || t_rdy < 0) $display("FAIL lockseq_ready got %0d want %0d", t_rdy, t_s[3]);
    else n_pass++;
  endtask

  task automatic test_timeout_retries();
    int   rises, last_rise, exp_r;
    logic prev;
    rises = 0; last_rise = 0; prev = 1'b1;
    do_reset(1'b0);
    for (int n = 1; n <= 300 * (T + P) + 5; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_timeout cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
      if (pll_rst && !prev) begin
        rises++;
        exp_r = (rises < 255) ? rises : 255;
        n_checks++;
        if (n - last_rise !== T + P) $display("FAIL timeout_period got %0d want %0d", n - last_rise, T + P);
        else n_pass++;
        n_checks++;
        if (retries !== 8'(exp_r)) $display("FAIL timeout_retries got %0d want %0d", retries, exp_r);
        else n_pass++;
        last_rise = n;
      end
      if (!pll_rst && prev) begin
        n_checks++;
        if (n - last_rise !== P) $display("FAIL timeout_width got %0d want %0d", n - last_rise, P);
        else n_pass++;
      end
      prev = pll_rst;
    end
    n_checks++;
    if (rises !== 300) $display("FAIL timeout_pulses got %0d want 300", rises);
    else n_pass++;
    n_checks++;
    if (retries !== 8'd255) $display("FAIL timeout_saturate got %0d want 255", retries);
    else n_pass++;
  endtask

  task automatic test_timeout_priority();
    do_reset(1'b0);
    for (int n = 1; n <= 60; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_priority cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
      if (n == 32) locked = 1'b1;
      if (n == 34) begin
        n_checks++;
        if ({sync_locked, pll_rst} !== 2'b10)
          $display("FAIL priority_pre got sync=%b pll=%b want sync=1 pll=0", sync_locked, pll_rst);
        else n_pass++;
      end
      if (n == 35) begin
        n_checks++;
        if ({pll_rst, retries} !== {1'b1, 8'd1})
          $display("FAIL priority_timeout got pll=%b retries=%0d want pll=1 retries=1", pll_rst, retries);
        else n_pass++;
      end
    end
  endtask

  task automatic test_stable_glitch();
    int  t_rise2, t_s0;
    bit  fell;
    t_rise2 = -1; t_s0 = -1; fell = 1'b0;
    do_reset(1'b1);
    for (int n = 1; n <= 40; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_glitch cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
      if (n > 2 && !sync_locked) fell = 1'b1;
      if (fell && t_rise2 < 0 && sync_locked) t_rise2 = n;
      if (t_s0 < 0 && !rst_stage[0]) t_s0 = n;
      if (n == 9)  locked = 1'b0;
      if (n == 12) locked = 1'b1;
    end
    n_checks++;
    if (t_s0 - t_rise2 !== L + 1 || t_rise2 < 0)
      $display("FAIL glitch_release got %0d want %0d", t_s0 - t_rise2, L + 1);
    else n_pass++;
  endtask

  task automatic test_loss_in_run();
    int t_drop;
    t_drop = -1;
    do_reset(1'b1);
    for (int n = 1; n <= 30; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_run cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if ({rst_stage, ready} !== 5'b0000_1) $display("FAIL run_state got stage=%b ready=%b want 0000/1", rst_stage, ready);
    else n_pass++;
    locked = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_loss cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
      if (t_drop < 0 && rst_stage == 4'hF && !ready && !pll_rst) t_drop = n;
    end
    n_checks++;
    if (t_drop !== 3) $display("FAIL loss_latency got %0d want 3", t_drop);
    else n_pass++;
    n_checks++;
    if (retries !== 8'd0) $display("FAIL loss_retries got %0d want 0", retries);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int t_s0, t_rdy;
    t_s0 = -1; t_rdy = -1;
    do_reset(1'b1);
    for (int n = 1; n <= 18; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_prerst cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
    end
    n_checks++;
    if (rst_stage !== 4'b1100) $display("FAIL midrel_stage got %b want 1100", rst_stage);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (dut_vec !== {1'b1, 1'b0, 4'hF, 1'b0, 8'd0})
      $display("FAIL async_reset got %h want %h", dut_vec, {1'b1, 1'b0, 4'hF, 1'b0, 8'd0});
    else n_pass++;
    @(negedge refclk);
    rst = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge refclk);
      n_checks++;
      if (dut_vec !== exp_vec) $display("FAIL model_replay cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
      else n_pass++;
      if (t_s0 < 0 && !rst_stage[0]) t_s0 = n;
      if (t_rdy < 0 && ready) t_rdy = n;
    end
    n_checks++;
    if ({t_s0, t_rdy} !== {32'(P + 1 + L), 32'(P + 1 + L + 3 * G)})
      $display("FAIL replay_timing got s0=%0d rdy=%0d want s0=%0d rdy=%0d", t_s0, t_rdy, P + 1 + L, P + 1 + L + 3 * G);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold;
    do_reset(1'b0);
    for (int s = 0; s < 150; s++) begin
      hold   = int'($urandom_range(1, 80));
      locked = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < hold; c++) begin
        @(negedge refclk);
        n_checks++;
        if (dut_vec !== exp_vec) $display("FAIL model_random cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
        else n_pass++;
        if ($urandom_range(0, 199) == 0) begin
          #2 rst = 1'b1;
          @(negedge refclk);
          n_checks++;
          if (dut_vec !== exp_vec) $display("FAIL model_random_rst cyc=%0d got %h want %h", cyc, dut_vec, exp_vec);
          else n_pass++;
          rst = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    test_reset();
    test_lock_sequence();
    test_timeout_retries();
    test_timeout_priority();
    test_stable_glitch();
    test_loss_in_run();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
